// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall controller bundle: ID/EX/MEM/WB hazard info, cache miss status,
// DMA handshake in, latch enables / forwarding / bus grant / statistics out.
interface pipeline_stall_ctrl_if #(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              use_rs;
  logic              use_rt;
  logic [REG_AW-1:0] dest_ex;
  logic [REG_AW-1:0] dest_m;
  logic [REG_AW-1:0] dest_wb;
  logic              regwrite_ex;
  logic              regwrite_m;
  logic              regwrite_wb;
  logic              is_load_ex;
  logic              halt_id;
  logic              i_miss;
  logic              d_miss;
  logic              i_ready;
  logic              d_ready;
  logic              br;
  logic              dma_done;
  logic              stat_clr;

  logic              pc_write;
  logic              id_write;
  logic              ex_write;
  logic              m_write;
  logic              wb_write;
  logic              flush_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              both_access;
  logic              bg;
  logic              dma_timeout;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output rs, rt, use_rs, use_rt, dest_ex, dest_m, dest_wb,
           regwrite_ex, regwrite_m, regwrite_wb, is_load_ex, halt_id,
           i_miss, d_miss, i_ready, d_ready, br, dma_done, stat_clr,
    input  pc_write, id_write, ex_write, m_write, wb_write, flush_ex,
           fwd_a, fwd_b, both_access, bg, dma_timeout, stall_count
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, dest_ex, dest_m, dest_wb,
           regwrite_ex, regwrite_m, regwrite_wb, is_load_ex, halt_id,
           i_miss, d_miss, i_ready, d_ready, br, dma_done, stat_clr,
    output pc_write, id_write, ex_write, m_write, wb_write, flush_ex,
           fwd_a, fwd_b, both_access, bg, dma_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// 5-stage pipeline hazard/stall controller: forwarding, load-use bubbles,
// cache-miss stalls and DMA bus arbitration with a grant watchdog.
module pipeline_stall_ctrl #(
  parameter int REG_AW  = 2,
  parameter int DMA_MAX = 16,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  pipeline_stall_ctrl_if.slave bus
);
  // state     | meaning
  // RUN/MISS_*| normal flow / I, D or both cache refills outstanding
  // DMA_WAIT  | one drain cycle before grant; DMA_GRANT | bus owned by DMA
  typedef enum logic [2:0] {
    S_RUN, S_MISS_I, S_MISS_D, S_MISS_BOTH, S_DMA_WAIT, S_DMA_GRANT
  } state_t;

  localparam int WD_W = (DMA_MAX > 2) ? $clog2(DMA_MAX) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(DMA_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  state_t           w_exit;
  logic             r_bg;
  logic             r_dma_timeout;
  logic             r_i_rdy;
  logic             r_d_rdy;
  logic             r_rearm;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [CNT_W-1:0] r_stall_count;

  logic [4:0] w_en;
  logic       w_flush;
  logic       w_both;
  logic       w_load_use;
  logic       w_dma_go;
  logic       w_i_seen;
  logic       w_d_seen;
  logic       w_wd_fire;
  logic       w_wd_trip;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] d_ex, input logic w_ex,
                                         input logic [REG_AW-1:0] d_m, input logic w_m,
                                         input logic [REG_AW-1:0] d_wb, input logic w_wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_src) begin
      if (w_ex && src == d_ex)      sel = 2'd1;
      else if (w_m && src == d_m)   sel = 2'd2;
      else if (w_wb && src == d_wb) sel = 2'd3;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(bus.use_rs, bus.rs, bus.dest_ex, bus.regwrite_ex,
                           bus.dest_m, bus.regwrite_m, bus.dest_wb, bus.regwrite_wb);
  assign w_fwd_b = fwd_sel(bus.use_rt, bus.rt, bus.dest_ex, bus.regwrite_ex,
                           bus.dest_m, bus.regwrite_m, bus.dest_wb, bus.regwrite_wb);
  assign w_load_use = bus.is_load_ex && bus.regwrite_ex &&
                      ((bus.use_rs && bus.rs == bus.dest_ex) || (bus.use_rt && bus.rt == bus.dest_ex));

  assign w_dma_go  = bus.br && !r_rearm;
  assign w_i_seen  = r_i_rdy || bus.i_ready;
  assign w_d_seen  = r_d_rdy || bus.d_ready;
  assign w_exit    = w_dma_go ? S_DMA_WAIT : S_RUN;
  assign w_wd_fire = (r_state == S_DMA_GRANT) && r_bg && (r_wd_cnt == '0);
  // simultaneous dma_done or br drop counts as a normal release
  assign w_wd_trip = w_wd_fire && bus.br && !bus.dma_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN, S_DMA_WAIT: begin
        if (bus.i_miss && bus.d_miss) w_next = S_MISS_BOTH;
        else if (bus.d_miss)          w_next = S_MISS_D;
        else if (bus.i_miss)          w_next = S_MISS_I;
        else                          w_next = w_dma_go ? S_DMA_GRANT : S_RUN;
      end
      S_MISS_I: begin
        if (bus.d_miss)       w_next = S_MISS_BOTH;
        else if (bus.i_ready) w_next = w_exit;
      end
      S_MISS_D: begin
        if (bus.i_miss)       w_next = S_MISS_BOTH;
        else if (bus.d_ready) w_next = w_exit;
      end
      S_MISS_BOTH: if (w_i_seen && w_d_seen) w_next = w_exit;
      S_DMA_GRANT: if (bus.dma_done || !bus.br || w_wd_fire) w_next = S_RUN;
      default:     w_next = S_RUN;
    endcase
  end

  always_comb begin
    w_en    = 5'b11111;
    w_flush = 1'b0;
    w_both  = 1'b0;
    case (r_state)
      S_RUN, S_DMA_WAIT: begin
        if (bus.d_miss) w_en = 5'b00000;
        else if (bus.i_miss) begin
          w_en    = 5'b00111;
          w_flush = 1'b1;
        end else if (w_load_use) begin
          w_en    = 5'b00011;
          w_flush = 1'b1;
        end
      end
      S_MISS_I: begin
        if (bus.d_miss) w_en = 5'b00000;
        else if (!bus.i_ready) begin
          w_en    = 5'b00111;
          w_flush = 1'b1;
        end
      end
      S_MISS_D: if (bus.i_miss || !bus.d_ready) w_en = 5'b00000;
      S_MISS_BOTH: begin
        w_both = 1'b1;
        if (!(w_i_seen && w_d_seen)) w_en = 5'b00000;
      end
      S_DMA_GRANT: begin
        if (bus.i_miss || bus.d_miss) w_en = 5'b00000;
        else if (w_load_use) begin
          w_en    = 5'b00011;
          w_flush = 1'b1;
        end
      end
      default: w_en = 5'b11111;
    endcase
    if (bus.halt_id) w_en[4:3] = 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bg          <= 1'b0;
      r_wd_cnt      <= '0;
      r_i_rdy       <= 1'b0;
      r_d_rdy       <= 1'b0;
      r_rearm       <= 1'b0;
      r_dma_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_bg <= (r_state == S_DMA_GRANT) && (w_next == S_DMA_GRANT);
      if (r_state != S_DMA_GRANT && w_next == S_DMA_GRANT) r_wd_cnt <= WD_LOAD;
      else if (r_bg && r_wd_cnt != '0)                       r_wd_cnt <= r_wd_cnt - 1'b1;
      r_i_rdy <= (w_next == S_MISS_BOTH) &&
                 (r_i_rdy || (bus.i_ready && (r_state == S_MISS_I || r_state == S_MISS_BOTH)));
      r_d_rdy <= (w_next == S_MISS_BOTH) &&
                 (r_d_rdy || (bus.d_ready && (r_state == S_MISS_D || r_state == S_MISS_BOTH)));
      r_rearm <= w_wd_trip || (r_rearm && bus.br);
      if (bus.stat_clr)    r_dma_timeout <= 1'b0;
      else if (w_wd_trip)  r_dma_timeout <= 1'b1;
      if (bus.stat_clr)                           r_stall_count <= '0;
      else if (!w_en[4] && r_stall_count != '1)   r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.pc_write    = w_en[4];
  assign bus.id_write    = w_en[3];
  assign bus.ex_write    = w_en[2];
  assign bus.m_write     = w_en[1];
  assign bus.wb_write    = w_en[0];
  assign bus.flush_ex    = w_flush;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.both_access = w_both;
  assign bus.bg          = r_bg;
  assign bus.dma_timeout = r_dma_timeout;
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic,
// every cycle compared against a miss/grant bookkeeping model.
module tb_pipeline_stall_ctrl;
  localparam int REG_AW  = 2;
  localparam int DMA_MAX = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) ifc ();
  pipeline_stall_ctrl #(.REG_AW(REG_AW), .DMA_MAX(DMA_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: which refills are outstanding, which deliveries already seen, DMA ownership
  bit m_ipend, m_dpend, m_igot, m_dgot, m_grant, m_bg, m_block, m_tmo;
  int m_age, m_cnt;
  logic [4:0] e_en;
  logic       e_fl, e_both;
  logic [1:0] e_fa, e_fb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fsel(input logic u, input logic [REG_AW-1:0] s);
    if (!u) return 2'd0;
    if (ifc.regwrite_ex && s == ifc.dest_ex) return 2'd1;
    if (ifc.regwrite_m && s == ifc.dest_m)   return 2'd2;
    if (ifc.regwrite_wb && s == ifc.dest_wb) return 2'd3;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    {ifc.rs, ifc.rt, ifc.dest_ex, ifc.dest_m, ifc.dest_wb} = '0;
    {ifc.use_rs, ifc.use_rt, ifc.regwrite_ex, ifc.regwrite_m, ifc.regwrite_wb} = '0;
    {ifc.is_load_ex, ifc.halt_id, ifc.i_miss, ifc.d_miss, ifc.i_ready, ifc.d_ready} = '0;
    {ifc.br, ifc.dma_done, ifc.stat_clr} = '0;
  endtask

  task automatic model_reset();
    {m_ipend, m_dpend, m_igot, m_dgot, m_grant, m_bg, m_block, m_tmo} = '0;
    m_age = 0;
    m_cnt = 0;
  endtask

  task automatic model_outputs();
    logic lu, miss_any;
    lu = ifc.is_load_ex && ifc.regwrite_ex &&
         ((ifc.use_rs && ifc.rs == ifc.dest_ex) || (ifc.use_rt && ifc.rt == ifc.dest_ex));
    miss_any = ifc.i_miss || ifc.d_miss;
    e_fa = fsel(ifc.use_rs, ifc.rs);
    e_fb = fsel(ifc.use_rt, ifc.rt);
    e_en = 5'b11111; e_fl = 1'b0; e_both = 1'b0;
    if (m_grant) begin
      if (miss_any) e_en = 5'b00000;
      else if (lu) begin e_en = 5'b00011; e_fl = 1'b1; end
    end else if (m_ipend && m_dpend) begin
      e_both = 1'b1;
      if (!((m_igot || ifc.i_ready) && (m_dgot || ifc.d_ready))) e_en = 5'b00000;
    end else if (m_ipend) begin
      if (ifc.d_miss) e_en = 5'b00000;
      else if (!ifc.i_ready) begin e_en = 5'b00111; e_fl = 1'b1; end
    end else if (m_dpend) begin
      if (ifc.i_miss || !ifc.d_ready) e_en = 5'b00000;
    end else begin
      if (ifc.d_miss) e_en = 5'b00000;
      else if (ifc.i_miss) begin e_en = 5'b00111; e_fl = 1'b1; end
      else if (lu) begin e_en = 5'b00011; e_fl = 1'b1; end
    end
    if (ifc.halt_id) e_en = e_en & 5'b00111;
  endtask

  task automatic model_update();
    bit go, fire, trip;
    go   = ifc.br && !m_block;
    fire = m_grant && m_bg && (m_age == DMA_MAX - 1);
    trip = fire && ifc.br && !ifc.dma_done;
    if (ifc.stat_clr) m_cnt = 0;
    else if (!e_en[4] && m_cnt < CNT_MAX) m_cnt++;
    m_tmo   = ifc.stat_clr ? 1'b0 : (m_tmo || trip);
    m_block = trip ? 1'b1 : (ifc.br ? m_block : 1'b0);
    if (m_grant) begin
      if (ifc.dma_done || !ifc.br || fire) begin
        m_grant = 1'b0; m_bg = 1'b0;
      end else begin
        if (m_bg) m_age++;
        m_bg = 1'b1;
      end
    end else if (m_ipend && m_dpend) begin
      if ((m_igot || ifc.i_ready) && (m_dgot || ifc.d_ready))
        {m_ipend, m_dpend, m_igot, m_dgot} = '0;
      else begin
        m_igot = m_igot || ifc.i_ready;
        m_dgot = m_dgot || ifc.d_ready;
      end
    end else if (m_ipend) begin
      if (ifc.d_miss) begin m_dpend = 1'b1; m_igot = ifc.i_ready; m_dgot = 1'b0; end
      else if (ifc.i_ready) m_ipend = 1'b0;
    end else if (m_dpend) begin
      if (ifc.i_miss) begin m_ipend = 1'b1; m_dgot = ifc.d_ready; m_igot = 1'b0; end
      else if (ifc.d_ready) m_dpend = 1'b0;
    end else if (ifc.i_miss || ifc.d_miss) begin
      m_ipend = ifc.i_miss; m_dpend = ifc.d_miss; m_igot = 1'b0; m_dgot = 1'b0;
    end else if (go) begin
      m_grant = 1'b1; m_age = 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_outputs();
    check($sformatf("comb@%0d", cyc),
          {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write,
           ifc.flush_ex, ifc.fwd_a, ifc.fwd_b, ifc.both_access},
          {e_en, e_fl, e_fa, e_fb, e_both});
    check($sformatf("regs@%0d", cyc), {ifc.bg, ifc.dma_timeout, ifc.stall_count},
          {m_bg, m_tmo, CNT_W'(m_cnt)});
  endtask

  task automatic at_pos();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    cyc++;
    #1;
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    at_neg();
    check("rst_en", {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write}, 5'b11111);
    check("rst_bg", ifc.bg, 1'b0);
    at_pos();
    reset = 1'b0;
    step();

    // load-use then forwarding from MEM once the bubble has gone in
    ifc.rs = 2'd1; ifc.use_rs = 1'b1; ifc.dest_ex = 2'd1; ifc.regwrite_ex = 1'b1; ifc.is_load_ex = 1'b1;
    at_neg();
    check("lu_en", {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write}, 5'b00011);
    check("lu_flush", ifc.flush_ex, 1'b1);
    check("lu_fwd_a", ifc.fwd_a, 2'd1);
    at_pos();
    ifc.regwrite_ex = 1'b0; ifc.is_load_ex = 1'b0; ifc.dest_m = 2'd1; ifc.regwrite_m = 1'b1;
    at_neg();
    check("lu_next_fwd_a", ifc.fwd_a, 2'd2);
    check("lu_next_en", {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write}, 5'b11111);
    at_pos();

    clear_inputs();
    ifc.dest_ex = 2'd2; ifc.dest_m = 2'd2; ifc.regwrite_ex = 1'b1; ifc.regwrite_m = 1'b1;
    ifc.rt = 2'd2; ifc.use_rt = 1'b1;
    at_neg(); check("fwd_b_ex", ifc.fwd_b, 2'd1); at_pos();
    ifc.regwrite_ex = 1'b0;
    at_neg(); check("fwd_b_mem", ifc.fwd_b, 2'd2); at_pos();

    // overlapping I then D miss, D delivered first
    clear_inputs();
    for (int c = 0; c <= 8; c++) begin
      ifc.i_miss  = (c <= 6);
      ifc.d_miss  = (c >= 1 && c <= 2);
      ifc.d_ready = (c == 3);
      ifc.i_ready = (c == 7);
      at_neg();
      if (c >= 2 && c <= 7) check($sformatf("both_access@+%0d", c), ifc.both_access, 1'b1);
      if (c >= 3 && c <= 6) check($sformatf("both_en@+%0d", c), ifc.pc_write, 1'b0);
      if (c == 7) check("both_exit_en",
                        {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write}, 5'b11111);
      if (c == 8) check("both_after", ifc.both_access, 1'b0);
      at_pos();
    end

    // DMA request during a D miss: miss completes, drain cycle, then grant
    clear_inputs();
    ifc.d_miss = 1'b1; step();
    ifc.br = 1'b1; step();
    ifc.d_miss = 1'b0; ifc.d_ready = 1'b1;
    at_neg();
    check("dmiss_exit_en", {ifc.pc_write, ifc.id_write, ifc.ex_write, ifc.m_write, ifc.wb_write}, 5'b11111);
    at_pos();
    ifc.d_ready = 1'b0;
    at_neg(); check("wait_bg", ifc.bg, 1'b0); at_pos();
    at_neg(); check("grant_first_bg", ifc.bg, 1'b0); at_pos();
    ifc.dma_done = 1'b1;
    at_neg(); check("grant_bg", ifc.bg, 1'b1); at_pos();
    ifc.dma_done = 1'b0; ifc.br = 1'b0;
    at_neg(); check("done_bg", ifc.bg, 1'b0); at_pos();

    // watchdog: br held without dma_done
    ifc.br = 1'b1;
    nb = 0;
    for (int c = 0; c < 26; c++) begin
      at_neg();
      if (ifc.bg) nb++;
      at_pos();
    end
    check("wd_bg_cycles", 32'(nb), 32'(DMA_MAX));
    check("wd_timeout", ifc.dma_timeout, 1'b1);
    ifc.br = 1'b0; step();
    ifc.br = 1'b1; step(); step();
    at_neg(); check("regrant_bg", ifc.bg, 1'b1); at_pos();
    ifc.br = 1'b0; step(); step();

    // stall counter saturation and clear
    ifc.stat_clr = 1'b1; step();
    ifc.stat_clr = 1'b0;
    at_neg(); check("clr_cnt", ifc.stall_count, 4'd0); check("clr_tmo", ifc.dma_timeout, 1'b0); at_pos();
    ifc.halt_id = 1'b1;
    for (int c = 0; c < 20; c++) step();
    ifc.halt_id = 1'b0;
    at_neg(); check("sat_cnt", ifc.stall_count, 4'd15); at_pos();
    ifc.stat_clr = 1'b1; step();
    ifc.stat_clr = 1'b0;
    at_neg(); check("clr2_cnt", ifc.stall_count, 4'd0); at_pos();

    // asynchronous reset while the DMA holds the bus
    ifc.br = 1'b1;
    step(); step(); step();
    at_neg();
    @(posedge clk);
    model_update();
    cyc++;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_grant_bg", ifc.bg, 1'b0);
    model_reset();
    ifc.br = 1'b0;
    at_neg();
    at_pos();
    reset = 1'b0;
    step();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      ifc.rs = 2'($urandom_range(0, 3));  ifc.rt = 2'($urandom_range(0, 3));
      ifc.dest_ex = 2'($urandom_range(0, 3)); ifc.dest_m = 2'($urandom_range(0, 3));
      ifc.dest_wb = 2'($urandom_range(0, 3));
      ifc.use_rs = 1'($urandom_range(0, 1)); ifc.use_rt = 1'($urandom_range(0, 1));
      ifc.regwrite_ex = 1'($urandom_range(0, 1)); ifc.regwrite_m = 1'($urandom_range(0, 1));
      ifc.regwrite_wb = 1'($urandom_range(0, 1)); ifc.is_load_ex = ($urandom_range(0, 2) == 0);
      ifc.halt_id  = ($urandom_range(0, 9) == 0);
      ifc.i_miss   = ($urandom_range(0, 7) == 0);
      ifc.d_miss   = ($urandom_range(0, 7) == 0);
      ifc.i_ready  = ($urandom_range(0, 3) == 0);
      ifc.d_ready  = ($urandom_range(0, 3) == 0);
      ifc.dma_done = ($urandom_range(0, 29) == 0);
      ifc.stat_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) ifc.br = ~ifc.br;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
